// File: rtl/chimp_round_ctrl_if.sv
// Handshake and status bundle between the chimp round controller and its
// environment (board datapath plus top-level game FSM).
`timescale 1ns/1ps
interface chimp_round_ctrl_if;
  logic       iStart;
  logic       iAbort;
  logic [4:0] iLevel;
  logic       iDoneLoad;
  logic       iClickValid;
  logic       iClickCorrect;
  logic       oResetBoard;
  logic       oLoadEnable;
  logic [4:0] oLoadNum;
  logic [7:0] oRandNum;
  logic       oShowEnable;
  logic [4:0] oChooseNum;
  logic       oBusy;
  logic       oRoundWin;
  logic       oRoundLose;
  logic [2:0] oState;

  modport master (
    input  iStart, iAbort, iLevel, iDoneLoad, iClickValid, iClickCorrect,
    output oResetBoard, oLoadEnable, oLoadNum, oRandNum, oShowEnable,
           oChooseNum, oBusy, oRoundWin, oRoundLose, oState
  );

  modport slave (
    output iStart, iAbort, iLevel, iDoneLoad, iClickValid, iClickCorrect,
    input  oResetBoard, oLoadEnable, oLoadNum, oRandNum, oShowEnable,
           oChooseNum, oBusy, oRoundWin, oRoundLose, oState
  );
endinterface

// File: rtl/chimp_round_ctrl.sv
// Chimp memory game round controller: clears the board, places 1..N at LFSR
// cells via a strobe/ack handshake, then tracks the player's clicks to win/lose.
`timescale 1ns/1ps
module chimp_round_ctrl #(
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int         MAX_LEVEL = 27
) (
  input  logic                  clk,
  input  logic                  iResetn,
  chimp_round_ctrl_if.master    bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_LWAIT = 3'd3,
    S_SHOW  = 3'd4,
    S_PLAY  = 3'd5,
    S_WIN   = 3'd6,
    S_LOSE  = 3'd7
  } state_t;

  localparam logic [4:0] MAX_LEVEL_L = 5'(MAX_LEVEL);

  state_t     state_reg, state_next;
  logic [7:0] lfsr_reg;
  logic       lfsr_fb;
  logic [4:0] load_num_reg, load_num_next;
  logic [4:0] choose_num_reg, choose_num_next;
  logic [4:0] n_reg, n_next;
  logic [4:0] level_clamped;

  // x^8 + x^6 + x^5 + x^4 + 1 : feedback from bits 7, 5, 4, 3
  assign lfsr_fb       = ^(lfsr_reg & 8'b1011_1000);
  assign level_clamped = (bus.iLevel > MAX_LEVEL_L) ? MAX_LEVEL_L : bus.iLevel;

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state_reg      <= S_IDLE;
      lfsr_reg       <= LFSR_SEED;
      load_num_reg   <= 5'd0;
      choose_num_reg <= 5'd0;
      n_reg          <= 5'd4;
    end else begin
      state_reg      <= state_next;
      lfsr_reg       <= {lfsr_reg[6:0], lfsr_fb};
      load_num_reg   <= load_num_next;
      choose_num_reg <= choose_num_next;
      n_reg          <= n_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    load_num_next   = load_num_reg;
    choose_num_next = choose_num_reg;
    n_next          = n_reg;
    if (bus.iAbort) begin
      state_next = S_IDLE;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (bus.iStart) begin
            n_next        = level_clamped + 5'd4;
            load_num_next = 5'd1;
            state_next    = S_CLEAR;
          end
        end
        S_CLEAR: state_next = S_LOAD;
        S_LOAD:  state_next = S_LWAIT;
        S_LWAIT: begin
          // A nack means the cell was occupied; retry the same number at the
          // next LFSR position.
          if (bus.iDoneLoad && (load_num_reg == n_reg)) begin
            choose_num_next = 5'd1;
            state_next      = S_SHOW;
          end else if (bus.iDoneLoad) begin
            load_num_next = load_num_reg + 5'd1;
            state_next    = S_LOAD;
          end else begin
            state_next = S_LOAD;
          end
        end
        S_SHOW: begin
          if (bus.iClickValid && bus.iClickCorrect) begin
            choose_num_next = 5'd2;
            state_next      = S_PLAY;
          end else if (bus.iClickValid) begin
            state_next = S_LOSE;
          end
        end
        S_PLAY: begin
          if (bus.iClickValid && bus.iClickCorrect) begin
            if (choose_num_reg == n_reg) state_next = S_WIN;
            else choose_num_next = choose_num_reg + 5'd1;
          end else if (bus.iClickValid) begin
            state_next = S_LOSE;
          end
        end
        S_WIN:   state_next = S_IDLE;
        S_LOSE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Every output decodes registered state, so nothing glitches from inputs.
  assign bus.oResetBoard = (state_reg == S_CLEAR);
  assign bus.oLoadEnable = (state_reg == S_LOAD);
  assign bus.oLoadNum    = (state_reg == S_LOAD) ? load_num_reg : 5'd0;
  assign bus.oRandNum    = iResetn ? lfsr_reg : 8'd0;
  assign bus.oShowEnable = (state_reg == S_SHOW);
  assign bus.oChooseNum  = choose_num_reg;
  assign bus.oBusy       = (state_reg != S_IDLE);
  assign bus.oRoundWin   = (state_reg == S_WIN);
  assign bus.oRoundLose  = (state_reg == S_LOSE);
  assign bus.oState      = state_reg;

endmodule

// File: tb/tb_chimp_round_ctrl.sv
// Self-checking bench for chimp_round_ctrl: a board datapath model answers the
// load handshake, and round outcomes are predicted from the game rules.
`timescale 1ns/1ps
module tb_chimp_round_ctrl;

  logic clk = 1'b0;
  logic iResetn;
  always #5 clk = ~clk;

  chimp_round_ctrl_if bus ();

  chimp_round_ctrl #(.LFSR_SEED(8'hA5), .MAX_LEVEL(27)) dut (
    .clk     (clk),
    .iResetn (iResetn),
    .bus     (bus)
  );

  typedef struct {
    int level;
    int exp_n;
    int nack;
    int exp_strobes;
    int wrong_at;
    bit start_mid;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wins  = 0;
  int loses = 0;
  int clear_seen = 0;

  logic [63:0] occupied;
  bit  use_board;
  int  nack_num;
  bit  nack_done;
  int  s_num[$];
  int  s_rand[$];
  int  s_cyc[$];
  bit  s_ack[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_model(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int any_output();
    return int'(|{bus.oResetBoard, bus.oLoadEnable, bus.oLoadNum, bus.oRandNum,
                  bus.oShowEnable, bus.oChooseNum, bus.oBusy, bus.oRoundWin,
                  bus.oRoundLose, bus.oState});
  endfunction

  // One clock: the datapath model answers the strobe seen in the cycle just ended.
  task automatic tick();
    logic       prev_load;
    logic       prev_clear;
    logic [4:0] prev_num;
    logic [7:0] prev_rand;
    bit         ack;
    prev_load  = bus.oLoadEnable;
    prev_clear = bus.oResetBoard;
    prev_num   = bus.oLoadNum;
    prev_rand  = bus.oRandNum;
    @(posedge clk);
    #1;
    bus.iStart = 1'b0; bus.iAbort = 1'b0;
    bus.iClickValid = 1'b0; bus.iClickCorrect = 1'b0;
    bus.iDoneLoad = 1'b0;
    if (prev_clear) begin
      occupied = '0;
      clear_seen++;
    end
    if (prev_load) begin
      ack = 1'b1;
      if (int'(prev_num) == nack_num && !nack_done) begin
        ack = 1'b0;
        nack_done = 1'b1;
      end else if (use_board && occupied[prev_rand[5:0]]) begin
        ack = 1'b0;
      end
      if (ack) occupied[prev_rand[5:0]] = 1'b1;
      s_num.push_back(int'(prev_num));
      s_rand.push_back(int'(prev_rand));
      s_cyc.push_back(cyc);
      s_ack.push_back(ack);
      bus.iDoneLoad = ack;
    end
    cyc++;
    if (bus.oRoundWin)  wins++;
    if (bus.oRoundLose) loses++;
  endtask

  task automatic load_round(input int level, input int exp_n);
    int t0, clears, clear_cyc, show_cyc, errs, expect_num;
    s_num.delete(); s_rand.delete(); s_cyc.delete(); s_ack.delete();
    nack_done = 1'b0;
    bus.iLevel = 5'(level);
    bus.iStart = 1'b1;
    t0 = cyc;
    tick();
    clears = 0; clear_cyc = -1; show_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      if (bus.oResetBoard) begin clears++; clear_cyc = cyc; end
      if (bus.oShowEnable) begin show_cyc = cyc; break; end
      tick();
    end
    check("load_reaches_show", int'(show_cyc >= 0), 1);
    check("clear_count", clears, 1);
    check("clear_cycle", clear_cyc, t0 + 1);
    errs = 0; expect_num = 1;
    for (int i = 0; i < s_num.size(); i++) begin
      if (s_num[i] != expect_num) errs++;
      if (s_cyc[i] != t0 + 2 + 2 * i) errs++;
      if (i > 0 && s_num[i] == s_num[i-1] && s_rand[i] == s_rand[i-1]) errs++;
      if (s_ack[i]) expect_num++;
    end
    check("load_sequence_errors", errs, 0);
    check("numbers_placed", expect_num - 1, exp_n);
    check("last_load_num", (s_num.size() > 0) ? s_num[s_num.size()-1] : -1, exp_n);
    check("show_cycle", show_cyc, t0 + 2 + 2 * s_num.size());
    check("choose_at_show", int'(bus.oChooseNum), 1);
  endtask

  // Click numbers 1..n in order; click wrong_at (1-based) is wrong, 0 = none.
  task automatic play(input int n, input int wrong_at, input bit start_mid);
    int  w0, l0;
    bit  decided;
    w0 = wins; l0 = loses; decided = 1'b0;
    for (int k = 1; k <= n && !decided; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (start_mid && k == 3) begin
        bus.iStart = 1'b1;
        tick();
        check("start_in_play_state", int'(bus.oState), 5);
        check("start_in_play_choose", int'(bus.oChooseNum), 3);
      end
      bus.iClickValid   = 1'b1;
      bus.iClickCorrect = (k != wrong_at);
      tick();
      if (k == wrong_at) begin
        decided = 1'b1;
        check("lose_pulse", int'(bus.oRoundLose), 1);
        check("lose_state", int'(bus.oState), 7);
      end else if (k == n) begin
        decided = 1'b1;
        check("win_pulse", int'(bus.oRoundWin), 1);
        check("win_state", int'(bus.oState), 6);
      end else begin
        check("show_after_click", int'(bus.oShowEnable), 0);
        check("choose_step", int'(bus.oChooseNum), k + 1);
      end
    end
    tick();
    check("idle_after_result", int'(bus.oState), 0);
    check("busy_after_result", int'(bus.oBusy), 0);
    bus.iClickValid = 1'b1; bus.iClickCorrect = 1'b1;
    tick();
    check("idle_click_dropped", int'(bus.oState), 0);
    check("win_pulses", wins - w0, int'(wrong_at == 0));
    check("lose_pulses", loses - l0, int'(wrong_at != 0));
  endtask

  vec_t vecs[6];
  logic [7:0] lv[300];

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int zeros, per_err, early_rep, step_err, s0, c0, n, wa, lvl, guard;
    iResetn = 1'b0;
    bus.iStart = 1'b0; bus.iAbort = 1'b0; bus.iLevel = 5'd0; bus.iDoneLoad = 1'b0;
    bus.iClickValid = 1'b0; bus.iClickCorrect = 1'b0;
    occupied = '0; use_board = 1'b0; nack_num = 0; nack_done = 1'b0;

    // Reset and release
    #1;
    check("reset_outputs_zero", any_output(), 0);
    repeat (3) @(posedge clk);
    #1;
    iResetn = 1'b1;
    #1;
    check("release_rand_seed", int'(bus.oRandNum), 'hA5);
    check("release_state", int'(bus.oState), 0);
    check("release_choose", int'(bus.oChooseNum), 0);
    tick();
    check("first_lfsr_step", int'(bus.oRandNum), int'(lfsr_model(8'hA5)));

    // Reset asserted while loading
    bus.iLevel = 5'd0; bus.iStart = 1'b1;
    tick();
    guard = 0;
    while (bus.oState != 3'd2 && guard < 10) begin tick(); guard++; end
    check("reached_load", int'(bus.oState), 2);
    #2 iResetn = 1'b0;
    #1;
    check("async_reset_outputs_zero", any_output(), 0);
    @(posedge clk); #1;
    check("held_reset_outputs_zero", any_output(), 0);
    iResetn = 1'b1;
    #1;
    check("rereset_rand_seed", int'(bus.oRandNum), 'hA5);
    check("rereset_state", int'(bus.oState), 0);
    tick();
    $display("reset sequence done at cycle %0d", cyc);

    // Directed rounds
    vecs[0] = '{level: 0,  exp_n: 4,  nack: 0, exp_strobes: 4,  wrong_at: 0, start_mid: 1'b0};
    vecs[1] = '{level: 0,  exp_n: 4,  nack: 2, exp_strobes: 5,  wrong_at: 3, start_mid: 1'b1};
    vecs[2] = '{level: 5,  exp_n: 9,  nack: 0, exp_strobes: 9,  wrong_at: 9, start_mid: 1'b0};
    vecs[3] = '{level: 27, exp_n: 31, nack: 0, exp_strobes: 31, wrong_at: 0, start_mid: 1'b0};
    vecs[4] = '{level: 28, exp_n: 31, nack: 0, exp_strobes: 31, wrong_at: 1, start_mid: 1'b0};
    vecs[5] = '{level: 31, exp_n: 31, nack: 0, exp_strobes: 31, wrong_at: 0, start_mid: 1'b0};
    use_board = 1'b0;
    for (int r = 0; r < 6; r++) begin
      nack_num = vecs[r].nack;
      load_round(vecs[r].level, vecs[r].exp_n);
      check("strobe_count", s_num.size(), vecs[r].exp_strobes);
      play(vecs[r].exp_n, vecs[r].wrong_at, vecs[r].start_mid);
      $display("round %0d level=%0d n=%0d strobes=%0d wrong_at=%0d wins=%0d loses=%0d",
               r, vecs[r].level, vecs[r].exp_n, s_num.size(), vecs[r].wrong_at, wins, loses);
    end
    nack_num = 0;

    // Free-running LFSR
    for (int i = 0; i < 300; i++) begin
      lv[i] = bus.oRandNum;
      tick();
    end
    zeros = 0; per_err = 0; early_rep = 0; step_err = 0;
    for (int i = 0; i < 300; i++) if (lv[i] == 8'd0) zeros++;
    for (int i = 0; i < 45; i++) if (lv[i+255] != lv[i]) per_err++;
    for (int j = 1; j < 255; j++) if (lv[j] == lv[0]) early_rep++;
    for (int i = 0; i < 299; i++) if (lv[i+1] != lfsr_model(lv[i])) step_err++;
    check("lfsr_zero_count", zeros, 0);
    check("lfsr_period_errors", per_err, 0);
    check("lfsr_early_repeats", early_rep, 0);
    check("lfsr_step_errors", step_err, 0);
    $display("lfsr run 300 cycles zeros=%0d period_err=%0d", zeros, per_err);

    // Abort while waiting for a load ack
    s_num.delete(); s_rand.delete(); s_cyc.delete(); s_ack.delete();
    bus.iLevel = 5'd3; bus.iStart = 1'b1;
    tick();
    guard = 0;
    while (bus.oState != 3'd3 && guard < 10) begin tick(); guard++; end
    check("reached_lwait", int'(bus.oState), 3);
    s0 = s_num.size(); c0 = clear_seen;
    n = wins + loses;
    bus.iAbort = 1'b1;
    tick();
    check("abort_state", int'(bus.oState), 0);
    check("abort_load_strobe", int'(bus.oLoadEnable), 0);
    repeat (3) tick();
    check("abort_no_strobes", s_num.size() - s0, 0);
    check("abort_no_clear", clear_seen - c0, 0);
    check("abort_no_result", wins + loses - n, 0);
    $display("abort in lwait done at cycle %0d", cyc);

    // Randomized rounds against the game-rule model
    use_board = 1'b1;
    for (int r = 0; r < 8; r++) begin
      lvl = $urandom_range(0, 31);
      n   = ((lvl > 27) ? 27 : lvl) + 4;
      wa  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, n);
      load_round(lvl, n);
      play(n, wa, 1'b0);
      $display("random round %0d level=%0d n=%0d attempts=%0d wrong_at=%0d wins=%0d loses=%0d",
               r, lvl, n, s_num.size(), wa, wins, loses);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chimp_round_ctrl.md
# chimp_round_ctrl

Round controller for the chimp memory game, sitting directly upstream of the chimp board datapath. On each round start it clears the board and places numbers 1..N into random cells through a strobe/acknowledge load handshake. It then shows the numbers, hides them after the first correct click, and tracks the expected next number until the player wins or loses. It drives the datapath's load, reset, show and choose-number inputs and reports round results to the top-level game FSM.

## Interface
- LFSR_SEED, 8'hA5, non-zero reset seed of the cell-position LFSR
- MAX_LEVEL, 27, highest accepted level; N = level + 4, so N ≤ 31
- clk  in  1  system clock, rising edge
- iResetn  in  1  asynchronous, active-low reset
- iStart  in  1  one-cycle pulse; begins a round; honoured only in IDLE
- iAbort  in  1  synchronous; forces IDLE next edge from any state
- iLevel  in  5  round level, sampled on accepted iStart; values > MAX_LEVEL clamp to MAX_LEVEL
- iDoneLoad  in  1  datapath ack; cell accepted the last load strobe
- iClickValid  in  1  one-cycle pulse per debounced click on a board cell
- iClickCorrect  in  1  qualified by iClickValid; clicked cell held oChooseNum
- oResetBoard  out  1  board clear strobe
- oLoadEnable  out  1  load strobe
- oLoadNum  out  5  number being placed
- oRandNum  out  8  LFSR value; [2:0] = X, [5:3] = Y, [7:6] unused by datapath
- oShowEnable  out  1  numbers visible
- oChooseNum  out  5  next number the player must click
- oBusy  out  1  state ≠ IDLE
- oRoundWin  out  1  one-cycle pulse
- oRoundLose  out  1  one-cycle pulse
- oState  out  3  state encoding, for debug

## Operation
- State encodings:
  - IDLE=0, CLEAR=1, LOAD=2, LWAIT=3, SHOW=4, PLAY=5, WIN=6, LOSE=7.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every cycle in every state.
  - Period 255; never reaches 0.
  - oRandNum is the LFSR register.
- IDLE:
  - All strobes are 0.
  - On iStart, latch N = min(iLevel, MAX_LEVEL) + 4 and set loadNum = 1, then go to CLEAR.
- CLEAR:
  - oResetBoard = 1 for exactly one cycle, then go to LOAD.
- LOAD:
  - oLoadEnable = 1 and oLoadNum = loadNum for exactly one cycle, then go to LWAIT.
  - iDoneLoad is ignored in this state.
- LWAIT:
  - oLoadEnable = 0.
  - If iDoneLoad = 1 and loadNum = N, go to SHOW.
  - If iDoneLoad = 1 and loadNum < N, increment loadNum and go to LOAD.
  - If iDoneLoad = 0 (cell occupied), go to LOAD and retry the same loadNum at the new LFSR cell.
- SHOW:
  - oShowEnable = 1, oChooseNum = 1.
  - iClickValid with iClickCorrect = 1: chooseNum = 2, go to PLAY (hides the numbers).
  - iClickValid with iClickCorrect = 0: go to LOSE.
- PLAY:
  - oShowEnable = 0.
  - On a correct click: if chooseNum = N go to WIN, otherwise increment chooseNum.
  - On a wrong click: go to LOSE.
- WIN / LOSE:
  - Pulse the matching result output for one cycle, then go to IDLE.
- iAbort:
  - Has priority over every transition; next state is IDLE.
  - No result pulse, no board clear. The next round's CLEAR wipes the board.
- iStart outside IDLE is ignored, and N is not re-sampled.
- Arithmetic:
  - loadNum and chooseNum are 5-bit and never exceed N ≤ 31, so no wrap.
  - N computation is 5-bit; clamping guarantees no overflow.

## Timing
- Reset (iResetn low, asynchronous):
  - All outputs 0, state IDLE, LFSR = LFSR_SEED, loadNum = 0, chooseNum = 0, N = 4.
  - Release is synchronous to the next edge.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- Round timeline, with iStart sampled at edge t:
  - CLEAR during cycle t+1.
  - First load strobe in cycle t+2.
  - Each placement attempt takes 2 cycles, so a collision-free load takes 2N cycles.
  - SHOW is entered at t+2+2N.
- The datapath registers oDoneLoad one edge after the strobe; LWAIT samples it in exactly that cycle.
- Clicks are acted on only in SHOW and PLAY, one per cycle; clicks in any other state are dropped.
- A result pulse appears one cycle after the deciding click, and IDLE follows one cycle later.
- Reset mid-round aborts immediately; outputs do not glitch high.

## Test plan
- Hold iResetn low during LOAD: all outputs are 0 asynchronously, oState = 0, and after release oRandNum = 8'hA5.
- iLevel = 0, iStart at t, model datapath always acks:
  - oResetBoard is high only in cycle t+1.
  - Strobes in cycles t+2, t+4, t+6, t+8 carry oLoadNum = 1, 2, 3, 4.
  - oShowEnable rises at t+10.
- Model nacks the first attempt for number 2: number 2 is strobed twice with differing oRandNum, 5 strobes total, and no number is skipped.
- After a 4-number load, send correct clicks 1..4:
  - oShowEnable falls after the first click.
  - oChooseNum steps 2, 3, 4.
  - oRoundWin pulses once, then IDLE.
- Send a wrong click while oChooseNum = 3: oRoundLose pulses once, no oRoundWin. A concurrent iStart during PLAY is ignored.
- iLevel = 31: N clamps to 31, oLoadNum reaches 31. Over 300 free-running cycles the LFSR is never 0 and repeats with period 255.
- iAbort asserted in LWAIT: IDLE next cycle, with no result pulse and no strobes.
